// File: rtl/shift_writeback_pkg.sv
// Shared CPU package: shifter FSM state encoding and default datapath sizes.
// Imported by shift_writeback, shift_counter and shift_writeback_if.
package shift_writeback_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sw_state_e;

endpackage

// File: rtl/shift_writeback_if.sv
// Bus/handshake bundle between the CPU datapath and the Z writeback shifter.
// With ROTATE_EN defined, the bundle also carries shift_rotate.
interface shift_writeback_if
  import shift_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic [WIDTH-1:0] DATA;
  logic [WIDTH-1:0] from_shifter;
  logic             Z_in;
  logic             Z_out;
  logic             shift_start;
  logic             shift_dir;
  logic [CNT_W-1:0] shift_count;
`ifdef ROTATE_EN
  logic             shift_rotate;
`endif
  logic [WIDTH-1:0] REG_OUT_Z;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output DATA, from_shifter, Z_in, Z_out, shift_start, shift_dir, shift_count,
`ifdef ROTATE_EN
    output shift_rotate,
`endif
    input  REG_OUT_Z, carry_out, busy, done
  );

  modport slave (
    input  DATA, from_shifter, Z_in, Z_out, shift_start, shift_dir, shift_count,
`ifdef ROTATE_EN
    input  shift_rotate,
`endif
    output REG_OUT_Z, carry_out, busy, done
  );

endinterface

// File: rtl/shift_writeback_shift_counter.sv
// Down-counter for the iterative shifter: load, decrement and zero/last flags.
// It never decrements below zero.
module shift_counter
  import shift_writeback_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign zero = (cnt_reg == '0);
  assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/shift_writeback.sv
// Z register with capture from the combinational shifter and an iterative
// one-bit-per-cycle shift engine; rotate mode is built when ROTATE_EN is defined.
module shift_writeback
  import shift_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  shift_writeback_if.slave   bus
);

  sw_state_e        state_reg, state_next;
  logic [WIDTH-1:0] z_reg, z_next;
  logic             carry_reg, carry_next;
  logic             dir_reg, dir_next;
  logic             rot_reg, rot_next;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [WIDTH-1:0] shl_val, shr_val;
  logic             fill_l, fill_r;

  shift_counter #(
    .CNT_W (CNT_W)
  ) u_shift_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (bus.shift_count),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Vacated bit: zero for logical shifts, the ejected bit when rotating.
  assign fill_l = rot_reg & z_reg[WIDTH-1];
  assign fill_r = rot_reg & z_reg[0];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shl_val[gi] = fill_l;
      end else begin : g_lsb_n
        assign shl_val[gi] = z_reg[gi-1];
      end
      if (gi == WIDTH-1) begin : g_msb
        assign shr_val[gi] = fill_r;
      end else begin : g_msb_n
        assign shr_val[gi] = z_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    z_next     = z_reg;
    carry_next = carry_reg;
    dir_next   = dir_reg;
    rot_next   = rot_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // shift_start has priority over a simultaneous capture.
        if (bus.shift_start) begin
          z_next   = bus.DATA;
          dir_next = bus.shift_dir;
`ifdef ROTATE_EN
          rot_next = bus.shift_rotate;
`else
          rot_next = 1'b0;
`endif
          cnt_load = 1'b1;
          if (bus.shift_count == '0) begin
            carry_next = 1'b0;
            state_next = ST_DONE;
          end else begin
            state_next = ST_SHIFT;
          end
        end else if (bus.Z_in) begin
          z_next = bus.from_shifter;
        end
      end

      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (dir_reg) begin
          z_next     = shr_val;
          carry_next = z_reg[0];
        end else begin
          z_next     = shl_val;
          carry_next = z_reg[WIDTH-1];
        end
        if (cnt_last || cnt_zero) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      z_reg     <= '0;
      carry_reg <= 1'b0;
      dir_reg   <= 1'b0;
      rot_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      z_reg     <= z_next;
      carry_reg <= carry_next;
      dir_reg   <= dir_next;
      rot_reg   <= rot_next;
    end
  end

  assign bus.REG_OUT_Z = bus.Z_out ? z_reg : '0;
  assign bus.carry_out = carry_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shift_writeback.sv
// Directed self-checking bench for shift_writeback (16-bit, 4-bit count).
// Define ROTATE_EN on both RTL and bench to include the rotate test.
module tb_shift_writeback;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   busy_cycles;
  logic done_seen;

  shift_writeback_if #(.WIDTH(16), .CNT_W(4)) sw ();

  shift_writeback #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(sw.busy), 32'd0);
    chk({tag, "_done"}, 32'(sw.done), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    sw.DATA         = '0;
    sw.from_shifter = '0;
    sw.Z_in         = 1'b0;
    sw.Z_out        = 1'b1;
    sw.shift_start  = 1'b0;
    sw.shift_dir    = 1'b0;
    sw.shift_count  = '0;
`ifdef ROTATE_EN
    sw.shift_rotate = 1'b0;
`endif

    // Reset state
    step();
    step();
    chk("rst_z", 32'(sw.REG_OUT_Z), 32'h0);
    chk("rst_carry", 32'(sw.carry_out), 32'd0);
    idle_outputs("rst");
    reset = 1'b0;
    step();
    $display("txn reset: Z=%h carry=%0d", sw.REG_OUT_Z, sw.carry_out);

    // Left shift by 3 of ABAA, with a stray start/capture while busy
    sw.DATA = 16'hABAA; sw.shift_dir = 1'b0; sw.shift_count = 4'd3; sw.shift_start = 1'b1;
    step();
    sw.shift_start = 1'b0;
    chk("l3_c1_busy", 32'(sw.busy), 32'd1);
    chk("l3_c1_done", 32'(sw.done), 32'd0);
    chk("l3_c1_z", 32'(sw.REG_OUT_Z), 32'hABAA);
    step();
    chk("l3_c2_z", 32'(sw.REG_OUT_Z), 32'h5754);
    chk("l3_c2_carry", 32'(sw.carry_out), 32'd1);
    sw.shift_start = 1'b1; sw.DATA = 16'hFFFF; sw.Z_in = 1'b1; sw.from_shifter = 16'h0F0F;
    step();
    sw.shift_start = 1'b0; sw.Z_in = 1'b0;
    chk("l3_c3_z", 32'(sw.REG_OUT_Z), 32'hAEA8);
    chk("l3_c3_done", 32'(sw.done), 32'd0);
    step();
    chk("l3_c4_busy", 32'(sw.busy), 32'd1);
    chk("l3_c4_done", 32'(sw.done), 32'd1);
    chk("l3_z", 32'(sw.REG_OUT_Z), 32'h5D50);
    chk("l3_carry", 32'(sw.carry_out), 32'd1);
    step();
    idle_outputs("l3_after");
    chk("l3_ignored_z", 32'(sw.REG_OUT_Z), 32'h5D50);
    $display("txn left3: Z=%h carry=%0d", sw.REG_OUT_Z, sw.carry_out);

    // Capture and drive; carry must survive the load
    sw.from_shifter = 16'h1234; sw.Z_in = 1'b1;
    step();
    sw.Z_in = 1'b0;
    chk("cap_z", 32'(sw.REG_OUT_Z), 32'h1234);
    chk("cap_carry", 32'(sw.carry_out), 32'd1);
    chk("cap_busy", 32'(sw.busy), 32'd0);
    sw.Z_out = 1'b0;
    #1;
    chk("cap_zout0", 32'(sw.REG_OUT_Z), 32'h0);
    sw.Z_out = 1'b1;
    $display("txn capture: Z=%h", sw.REG_OUT_Z);

    // Count 0 with a simultaneous capture: start wins, carry cleared
    sw.DATA = 16'hC3C3; sw.shift_count = 4'd0; sw.shift_start = 1'b1;
    sw.Z_in = 1'b1; sw.from_shifter = 16'h1111;
    step();
    sw.shift_start = 1'b0; sw.Z_in = 1'b0;
    chk("c0_done", 32'(sw.done), 32'd1);
    chk("c0_busy", 32'(sw.busy), 32'd1);
    chk("c0_z", 32'(sw.REG_OUT_Z), 32'hC3C3);
    chk("c0_carry", 32'(sw.carry_out), 32'd0);
    step();
    idle_outputs("c0_after");
    $display("txn count0: Z=%h carry=%0d", sw.REG_OUT_Z, sw.carry_out);

    // Right shift by 3 of ABAA
    sw.DATA = 16'hABAA; sw.shift_dir = 1'b1; sw.shift_count = 4'd3; sw.shift_start = 1'b1;
    busy_cycles = 0; done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      sw.shift_start = 1'b0;
      if (sw.busy) busy_cycles++;
      if (sw.done) begin done_seen = 1'b1; break; end
    end
    chk("r3_done_seen", 32'(done_seen), 32'd1);
    chk("r3_busy_cycles", 32'(busy_cycles), 32'd4);
    chk("r3_z", 32'(sw.REG_OUT_Z), 32'h1575);
    chk("r3_carry", 32'(sw.carry_out), 32'd0);
    step();
    $display("txn right3: Z=%h carry=%0d", sw.REG_OUT_Z, sw.carry_out);

    // Right shift by 15 of 8000
    sw.DATA = 16'h8000; sw.shift_dir = 1'b1; sw.shift_count = 4'd15; sw.shift_start = 1'b1;
    busy_cycles = 0; done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      sw.shift_start = 1'b0;
      if (sw.busy) busy_cycles++;
      if (sw.done) begin done_seen = 1'b1; break; end
    end
    chk("r15_done_seen", 32'(done_seen), 32'd1);
    chk("r15_busy_cycles", 32'(busy_cycles), 32'd16);
    chk("r15_z", 32'(sw.REG_OUT_Z), 32'h0001);
    chk("r15_carry", 32'(sw.carry_out), 32'd0);
    step();
    $display("txn right15: Z=%h carry=%0d", sw.REG_OUT_Z, sw.carry_out);

    // Set carry via a left shift of 8000 by 1, then abort a count-15 shift with reset
    sw.DATA = 16'h8000; sw.shift_dir = 1'b0; sw.shift_count = 4'd1; sw.shift_start = 1'b1;
    step();
    sw.shift_start = 1'b0;
    step();
    chk("l1_carry", 32'(sw.carry_out), 32'd1);
    step();
    sw.DATA = 16'h8000; sw.shift_dir = 1'b1; sw.shift_count = 4'd15; sw.shift_start = 1'b1;
    step();
    sw.shift_start = 1'b0;
    step();
    step();
    chk("abort_pre_busy", 32'(sw.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_z", 32'(sw.REG_OUT_Z), 32'h0);
    chk("abort_carry", 32'(sw.carry_out), 32'd0);
    idle_outputs("abort");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_hold_done", 32'(sw.done), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("abort_no_done", 32'(sw.done), 32'd0);
    end
    chk("abort_busy", 32'(sw.busy), 32'd0);
    chk("abort_z_after", 32'(sw.REG_OUT_Z), 32'h0);
    $display("txn abort: Z=%h busy=%0d", sw.REG_OUT_Z, sw.busy);

`ifdef ROTATE_EN
    // Rotate left by 3 of ABAA
    sw.DATA = 16'hABAA; sw.shift_dir = 1'b0; sw.shift_count = 4'd3;
    sw.shift_rotate = 1'b1; sw.shift_start = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      sw.shift_start = 1'b0; sw.shift_rotate = 1'b0;
      if (sw.done) begin done_seen = 1'b1; break; end
    end
    chk("rot_done_seen", 32'(done_seen), 32'd1);
    chk("rot_z", 32'(sw.REG_OUT_Z), 32'h5D55);
    chk("rot_carry", 32'(sw.carry_out), 32'd1);
    step();
    $display("txn rotl3: Z=%h carry=%0d", sw.REG_OUT_Z, sw.carry_out);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_writeback.md
SHIFT_WRITEBACK -- requirements
Module: shift_writeback

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data word width matching w_bus.
REQ-002 The block SHALL have parameter CNT_W, default 4, the shift-count width (log2 of WIDTH).
REQ-003 Port clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port DATA  input  WIDTH  w_bus value, the operand for an iterative shift.
REQ-006 Port from_shifter  input  WIDTH  combinational shifter result.
REQ-007 Port Z_in  input  1  capture from_shifter into Z.
REQ-008 Port Z_out  input  1  drive Z onto REG_OUT_Z.
REQ-009 Port shift_start  input  1  begin an iterative shift of DATA.
REQ-010 Port shift_dir  input  1  0 = left, 1 = right.
REQ-011 Port shift_count  input  CNT_W  number of bit positions, 0..WIDTH-1.
REQ-012 Port REG_OUT_Z  output  WIDTH  Z when Z_out=1, otherwise all zeros (OR-bus convention).
REQ-013 Port carry_out  output  1  last bit shifted out.
REQ-014 Port busy  output  1  high in SHIFT and DONE.
REQ-015 Port done  output  1  one-cycle pulse when the result is valid in Z.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 In IDLE, shift_start=1 SHALL load DATA into Z, latch shift_dir, load the counter with shift_count, and move to SHIFT (or to DONE if the count is 0).
REQ-018 In SHIFT, each cycle SHALL shift Z by one bit in the latched direction, zero-fill the vacated bit, copy the ejected bit to carry_out, and decrement the counter.
REQ-019 When the counter reaches 1, the next edge SHALL leave SHIFT for DONE; a shift of N takes exactly N SHIFT cycles.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 Z_in SHALL load Z from from_shifter in one cycle, in IDLE only; carry_out is unchanged by this load.
REQ-022 If shift_start and Z_in are both high in IDLE, shift_start SHALL win and Z_in is ignored.
REQ-023 shift_start and Z_in SHALL be ignored while busy=1.
REQ-024 REG_OUT_Z SHALL be combinational from Z and Z_out in every state; mid-shift values are visible.
REQ-025 For a 0-count shift, carry_out SHALL be cleared to 0.

Reset
REQ-026 Reset SHALL asynchronously force: state IDLE, Z=0, counter=0, carry_out=0, busy=0, done=0, REG_OUT_Z=0.
REQ-027 Reset in the middle of a shift SHALL abort it, with no done pulse.

Configuration
REQ-028 With ROTATE_EN defined, an extra input port shift_rotate (1 bit) SHALL be latched at start; when it is 1, the ejected bit wraps into the vacated position instead of a zero. carry_out behaviour is unchanged.
REQ-029 Without ROTATE_EN, the shift_rotate port SHALL be absent and all shifts are logical.

Structure
REQ-030 The state encoding (IDLE/SHIFT/DONE) and the default WIDTH/CNT_W constants SHALL live in the shared CPU package.
REQ-031 A sub-module shift_counter (load, decrement, zero flag) SHALL be the only sub-module.

Verification
REQ-032 Left shift: DATA=16'hABAA, shift_dir=0, shift_count=3, pulse shift_start -> busy for 4 cycles; done on the 4th cycle after start; Z=16'h5D50; carry_out=1.
REQ-033 Right shift: same DATA, shift_dir=1, count=3 -> Z=16'h1575; carry_out=0.
REQ-034 Capture and drive: from_shifter=16'h1234, Z_in=1 for 1 cycle, then Z_out=1 -> REG_OUT_Z=16'h1234; with Z_out=0 -> REG_OUT_Z=0.
REQ-035 Boundaries: count=0 -> done on the next cycle, Z=DATA, carry_out=0; count=15 right on 16'h8000 -> Z=16'h0001.
REQ-036 Reset and ignore rules: assert reset 2 cycles into a count-15 shift -> all outputs 0, no done; a second shift_start while busy -> ignored.
REQ-037 With ROTATE_EN and shift_rotate=1: left 3 on 16'hABAA -> Z=16'h5D55.
